// File: rtl/gca_pkg.sv
// Shared definitions for the Gray-converter arbiter: requester ids and
// output-register state encodings.
package gca_pkg;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/bin_gry.sv
// Combinational N-bit binary-to-Gray converter.
module bin_gry #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    // MSB passes through; every lower bit is the XOR of adjacent binary bits.
    assign gray = {bin[N-1], bin[N-1:1] ^ bin[N-2:0]};

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray converter between two
// valid/ready requesters. The result is registered with the id of its source.
// Optional feature: define GCA_STATS_EN to add saturating per-requester
// accepted-transfer counters (gnt0_cnt/gnt1_cnt, width CW).
module gray_conv_arbiter
    import gca_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [N-1:0]  req0_bin,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [N-1:0]  req1_bin,
    output logic          req1_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_gray,
    output logic          out_id,
    input  logic          out_ready
`ifdef GCA_STATS_EN
    ,
    output logic [CW-1:0] gnt0_cnt,
    output logic [CW-1:0] gnt1_cnt
`endif
);

    out_state_e   state;
    logic         last_gnt;
    logic         slot_free;
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic         sel_id;
    logic [N-1:0] sel_bin;
    logic [N-1:0] conv_gray;

    assign out_valid = (state == ST_FULL);

    // Arbitration: a lone valid wins; on a tie the requester not granted last wins.
    always_comb begin
        slot_free  = ~out_valid | out_ready;
        grant0     = req0_valid & (~req1_valid | (last_gnt == ID_REQ1));
        grant1     = req1_valid & (~req0_valid | (last_gnt == ID_REQ0));
        req0_ready = grant0 & slot_free;
        req1_ready = grant1 & slot_free;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        sel_id     = grant1 ? ID_REQ1 : ID_REQ0;
        sel_bin    = grant1 ? req1_bin : req0_bin;
    end

    bin_gry #(
        .N(N)
    ) u_bin_gry (
        .bin  (sel_bin),
        .gray (conv_gray)
    );

    // Output register FSM; last_gnt moves only on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_gray <= '0;
            out_id   <= ID_REQ0;
            last_gnt <= ID_REQ1;
        end else begin
            if (accept) begin
                last_gnt <= sel_id;
            end
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state    <= ST_FULL;
                        out_gray <= conv_gray;
                        out_id   <= sel_id;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (accept) begin
                            out_gray <= conv_gray;
                            out_id   <= sel_id;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

`ifdef GCA_STATS_EN
    // Saturating accepted-transfer counters, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else if (accept) begin
            if ((sel_id == ID_REQ0) && (gnt0_cnt != '1)) begin
                gnt0_cnt <= gnt0_cnt + CW'(1);
            end
            if ((sel_id == ID_REQ1) && (gnt1_cnt != '1)) begin
                gnt1_cnt <= gnt1_cnt + CW'(1);
            end
        end
    end
`else
    // CW only sizes the counters; keep it referenced when they are absent.
    logic [CW-1:0] unused_stats;
    assign unused_stats = '0;
`endif

endmodule
